// File: rtl/mux4_rr_sched_pkg.sv
// Shared definitions for the four-way round-robin mux scheduler.
// FSM encodings and a one-hot index helper.
package mux4_rr_sched_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] req_idx_t;

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    function automatic logic [N_REQ-1:0] onehot4(input req_idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_sched_rr_pick4.sv
// Combinational rotate-priority picker: first set req bit at or after ptr, mod 4.
module rr_pick4
    import mux4_rr_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  req_idx_t         ptr,
    output logic             any,
    output req_idx_t         idx
);

    req_idx_t cand;

    // Walk from farthest to nearest so the position closest to ptr wins.
    always_comb begin
        any  = |req;
        idx  = ptr;
        cand = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) idx = cand;
        end
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing a per-bit 4:1 select datapath among four requesters,
// with a registered valid/ready output stage.
module mux4_rr_sched
    import mux4_rr_sched_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] din,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        gnt,
    output logic [1:0]              sel,
    output logic                    y_valid,
    output logic [DATA_W-1:0]       y_data,
    output logic [1:0]              y_src,
    input  logic                    y_ready
);

    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    logic [0:0]       state;
    req_idx_t         ptr;
    logic [CNT_W-1:0] beat_cnt;
    logic             pick_any;
    req_idx_t         pick_idx;
    logic [DATA_W-1:0] mux_data;
    logic             accept;
    logic             last_beat;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    for (genvar b = 0; b < DATA_W; b++) begin : g_mux
        assign mux_data[b] = sel[1] ? (sel[0] ? din[3*DATA_W+b] : din[2*DATA_W+b])
                                    : (sel[0] ? din[DATA_W+b]   : din[b]);
    end

    assign accept    = (state == ST_GRANT) && req[sel] && (!y_valid || y_ready);
    assign last_beat = (beat_cnt == CNT_W'(HOLD_MAX - 1));
    assign ack       = accept ? onehot4(sel) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_ARB;
            ptr      <= '0;
            sel      <= '0;
            gnt      <= '0;
            beat_cnt <= '0;
            y_valid  <= 1'b0;
            y_data   <= '0;
            y_src    <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (pick_any) begin
                        sel      <= pick_idx;
                        gnt      <= onehot4(pick_idx);
                        beat_cnt <= '0;
                        state    <= ST_GRANT;
                    end
                end
                default: begin
                    // Release on the final allowed beat, or when the owner stops requesting.
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            state <= ST_ARB;
                            gnt   <= '0;
                            ptr   <= sel + 2'd1;
                        end
                    end else if (!req[sel]) begin
                        state <= ST_ARB;
                        gnt   <= '0;
                        ptr   <= sel + 2'd1;
                    end
                end
            endcase

            // Output register: a new beat overwrites a draining one in the same cycle.
            if (accept) begin
                y_valid <= 1'b1;
                y_data  <= mux_data;
                y_src   <= sel;
            end else if (y_ready) begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed, table-driven bench for mux4_rr_sched (HOLD_MAX=4 and HOLD_MAX=1 instances).
module tb_mux4_rr_sched;

    localparam logic [31:0] DIN0    = {8'h3C, 8'hA5, 8'h5A, 8'hC3};
    localparam logic [31:0] DIN_ALT = {8'h3C, 8'hA5, 8'hFF, 8'hC3};

    typedef struct {
        int          tid;
        bit          dut;
        logic [3:0]  req;
        logic        rdy;
        logic [31:0] din;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic        yv;
        logic [1:0]  src;
        logic [7:0]  data;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] din;
    logic        y_ready;

    logic [3:0]  ack0, gnt0, ack1, gnt1;
    logic [1:0]  sel0, sel1, src0, src1;
    logic        yv0, yv1;
    logic [7:0]  data0, data1;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vq[$];

    mux4_rr_sched #(.DATA_W(8), .HOLD_MAX(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
        .ack(ack0), .gnt(gnt0), .sel(sel0),
        .y_valid(yv0), .y_data(data0), .y_src(src0), .y_ready(y_ready)
    );

    mux4_rr_sched #(.DATA_W(8), .HOLD_MAX(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
        .ack(ack1), .gnt(gnt1), .sel(sel1),
        .y_valid(yv1), .y_data(data1), .y_src(src1), .y_ready(y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] word(input logic [31:0] d, input int i);
        return d[i*8 +: 8];
    endfunction

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 0; k < 4; k++) if (oh[k]) r = 2'(k);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input int tid, input bit dut, input logic [3:0] rq, input logic rd,
                       input logic [31:0] d, input logic [3:0] eg, input logic [3:0] ea,
                       input logic eyv, input logic [1:0] es, input logic [7:0] ed);
        vec_t v;
        v.tid = tid; v.dut = dut; v.req = rq; v.rdy = rd; v.din = d;
        v.gnt = eg; v.ack = ea; v.yv = eyv; v.src = es; v.data = ed;
        vq.push_back(v);
    endtask

    task automatic check_vec(input vec_t v, input int i);
        logic [3:0] g, a;
        logic [1:0] s, ys;
        logic       yv;
        logic [7:0] yd;
        string      tag;
        g  = v.dut ? gnt1  : gnt0;
        a  = v.dut ? ack1  : ack0;
        s  = v.dut ? sel1  : sel0;
        yv = v.dut ? yv1   : yv0;
        ys = v.dut ? src1  : src0;
        yd = v.dut ? data1 : data0;
        tag = $sformatf("t%0d_v%0d", v.tid, i);
        chk({tag, "_gnt"}, 32'(g), 32'(v.gnt));
        chk({tag, "_ack"}, 32'(a), 32'(v.ack));
        chk({tag, "_yvalid"}, 32'(yv), 32'(v.yv));
        if (v.gnt != 4'h0) chk({tag, "_sel"}, 32'(s), 32'(idx_of(v.gnt)));
        if (v.yv) begin
            chk({tag, "_ysrc"}, 32'(ys), 32'(v.src));
            chk({tag, "_ydata"}, 32'(yd), 32'(v.data));
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = 4'h0;
        y_ready = 1'b0;
        din     = DIN0;
        @(negedge clk);
        #1;
        chk("rst_gnt", 32'(gnt0), 32'h0);
        chk("rst_ack", 32'(ack0), 32'h0);
        chk("rst_sel", 32'(sel0), 32'h0);
        chk("rst_yvalid", 32'(yv0), 32'h0);
        chk("rst_ydata", 32'(data0), 32'h0);
        chk("rst_ysrc", 32'(src0), 32'h0);
        chk("rst_gnt_h1", 32'(gnt1), 32'h0);
        rst_n = 1'b1;
    endtask

    // Structural invariants on both instances, sampled mid-cycle.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            chk("inv_gnt_onehot0_d0", 32'($onehot0(gnt0)), 32'd1);
            chk("inv_ack_in_gnt_d0", 32'(ack0 & ~gnt0), 32'h0);
            chk("inv_ack_onehot0_d0", 32'($onehot0(ack0)), 32'd1);
            if (gnt0 != 4'h0) chk("inv_sel_d0", 32'(sel0), 32'(idx_of(gnt0)));
            chk("inv_gnt_onehot0_d1", 32'($onehot0(gnt1)), 32'd1);
            chk("inv_ack_in_gnt_d1", 32'(ack1 & ~gnt1), 32'h0);
            chk("inv_ack_onehot0_d1", 32'($onehot0(ack1)), 32'd1);
            if (gnt1 != 4'h0) chk("inv_sel_d1", 32'(sel1), 32'(idx_of(gnt1)));
        end
    end

    initial begin
        rst_n   = 1'b0;
        req     = 4'h0;
        din     = DIN0;
        y_ready = 1'b0;

        // Test 2: all four requesting, full throughput: 4 beats then one ARB cycle per grant.
        for (int g = 0; g <= 5; g++) begin
            add(2, 0, 4'hF, 1'b1, DIN0, 4'h0, 4'h0, g > 0, 2'((g - 1) & 3), word(DIN0, (g - 1) & 3));
            if (g < 5)
                for (int b = 0; b < 4; b++)
                    add(2, 0, 4'hF, 1'b1, DIN0, 4'b1 << (g & 3), 4'b1 << (g & 3),
                        b > 0, 2'(g & 3), word(DIN0, g & 3));
        end

        // Test 3: sole requester 2.
        for (int p = 0; p < 2; p++) begin
            add(3, 0, 4'b0100, 1'b1, DIN0, 4'h0, 4'h0, p > 0, 2'd2, 8'hA5);
            for (int b = 0; b < 4; b++)
                add(3, 0, 4'b0100, 1'b1, DIN0, 4'b0100, 4'b0100, b > 0, 2'd2, 8'hA5);
        end
        add(3, 0, 4'b0100, 1'b1, DIN0, 4'h0, 4'h0, 1'b1, 2'd2, 8'hA5);

        // Test 4: stall three cycles after the first beat; din changes underneath the held beat.
        add(4, 0, 4'b0010, 1'b1, DIN0,    4'h0,    4'h0,    1'b0, 2'd0, 8'h00);
        add(4, 0, 4'b0010, 1'b1, DIN0,    4'b0010, 4'b0010, 1'b0, 2'd0, 8'h00);
        add(4, 0, 4'b0010, 1'b0, DIN_ALT, 4'b0010, 4'h0,    1'b1, 2'd1, 8'h5A);
        add(4, 0, 4'b0010, 1'b0, DIN_ALT, 4'b0010, 4'h0,    1'b1, 2'd1, 8'h5A);
        add(4, 0, 4'b0010, 1'b0, DIN_ALT, 4'b0010, 4'h0,    1'b1, 2'd1, 8'h5A);
        add(4, 0, 4'b0010, 1'b1, DIN0,    4'b0010, 4'b0010, 1'b1, 2'd1, 8'h5A);
        add(4, 0, 4'b0010, 1'b1, DIN0,    4'b0010, 4'b0010, 1'b1, 2'd1, 8'h5A);
        add(4, 0, 4'b0010, 1'b1, DIN0,    4'b0010, 4'b0010, 1'b1, 2'd1, 8'h5A);
        add(4, 0, 4'b0010, 1'b1, DIN0,    4'h0,    4'h0,    1'b1, 2'd1, 8'h5A);
        add(4, 0, 4'b0010, 1'b1, DIN0,    4'b0010, 4'b0010, 1'b0, 2'd1, 8'h5A);

        // Test 5: requester 3 drops after two beats, requester 0 picked up after wrap.
        add(5, 0, 4'b1000, 1'b1, DIN0, 4'h0,    4'h0,    1'b0, 2'd0, 8'h00);
        add(5, 0, 4'b1001, 1'b1, DIN0, 4'b1000, 4'b1000, 1'b0, 2'd0, 8'h00);
        add(5, 0, 4'b1001, 1'b1, DIN0, 4'b1000, 4'b1000, 1'b1, 2'd3, 8'h3C);
        add(5, 0, 4'b0001, 1'b1, DIN0, 4'b1000, 4'h0,    1'b1, 2'd3, 8'h3C);
        add(5, 0, 4'b0001, 1'b1, DIN0, 4'h0,    4'h0,    1'b0, 2'd0, 8'h00);
        add(5, 0, 4'b0001, 1'b1, DIN0, 4'b0001, 4'b0001, 1'b0, 2'd0, 8'h00);
        add(5, 0, 4'b0001, 1'b1, DIN0, 4'b0001, 4'b0001, 1'b1, 2'd0, 8'hC3);

        // Test 6: HOLD_MAX=1 instance, requesters 0 and 2 strictly interleave.
        add(6, 1, 4'b0101, 1'b1, DIN0, 4'h0, 4'h0, 1'b0, 2'd0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            add(6, 1, 4'b0101, 1'b1, DIN0, (k % 2 == 0) ? 4'b0001 : 4'b0100,
                (k % 2 == 0) ? 4'b0001 : 4'b0100, 1'b0, 2'd0, 8'h00);
            add(6, 1, 4'b0101, 1'b1, DIN0, 4'h0, 4'h0, 1'b1,
                (k % 2 == 0) ? 2'd0 : 2'd2, (k % 2 == 0) ? 8'hC3 : 8'hA5);
        end

        for (int i = 0; i < vq.size(); i++) begin
            if (i == 0 || vq[i].tid != vq[i-1].tid) do_reset();
            req     = vq[i].req;
            y_ready = vq[i].rdy;
            din     = vq[i].din;
            #1;
            check_vec(vq[i], i);
            @(negedge clk);
        end

        // Test 1: async reset while granted and holding a stalled beat; ptr must return to 0.
        do_reset();
        req     = 4'b0001;
        y_ready = 1'b1;
        repeat (5) @(negedge clk);
        req     = 4'b0010;
        y_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("t1_pre_gnt", 32'(gnt0), 32'h2);
        chk("t1_pre_yvalid", 32'(yv0), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_async_gnt", 32'(gnt0), 32'h0);
        chk("t1_async_sel", 32'(sel0), 32'h0);
        chk("t1_async_ack", 32'(ack0), 32'h0);
        chk("t1_async_yvalid", 32'(yv0), 32'h0);
        chk("t1_async_ydata", 32'(data0), 32'h0);
        chk("t1_async_ysrc", 32'(src0), 32'h0);
        req     = 4'b0011;
        y_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t1_arb_gnt", 32'(gnt0), 32'h0);
        @(negedge clk);
        #1;
        chk("t1_ptr0_gnt", 32'(gnt0), 32'h1);
        chk("t1_ptr0_ack", 32'(ack0), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
